// File: rtl/fma16_pkg.sv
// Shared types and constants for the fma16 sequencer slice.
package fma16_pkg;

  localparam int unsigned FP16_W = 16;

  // Bit positions within dp_en
  localparam int unsigned EN_MUL = 0;
  localparam int unsigned EN_ALN = 1;
  localparam int unsigned EN_NRM = 2;
  localparam int unsigned EN_RND = 3;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    ALN,
    NRM,
    RND,
    WB
  } state_t;

  typedef struct packed {
    logic nv;
    logic of;
    logic uf;
    logic nx;
  } flags_t;

endpackage

// File: rtl/fma16_outq.sv
// Synchronous FIFO buffering {result,flags} entries; DEPTH must be a power of two.
module fma16_outq #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fma16_seq_ctrl.sv
// Sequencer for the multi-cycle fma16 datapath with an output result queue.
// Define FMA16_PERF_EN to add the perf_ops/perf_stall counters.
module fma16_seq_ctrl
  import fma16_pkg::*;
#(
  parameter int unsigned MUL_CYC  = 1,
  parameter int unsigned ALN_CYC  = 1,
  parameter int unsigned NRM_CYC  = 1,
  parameter int unsigned RND_CYC  = 1,
  parameter int unsigned OQ_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP16_W-1:0] in_x,
  input  logic [FP16_W-1:0] in_y,
  input  logic [FP16_W-1:0] in_z,
  input  logic [3:0]        in_ctrl,
  output logic [FP16_W-1:0] dp_x,
  output logic [FP16_W-1:0] dp_y,
  output logic [FP16_W-1:0] dp_z,
  output logic [3:0]        dp_ctrl,
  output logic [3:0]        dp_en,
  input  logic [FP16_W-1:0] dp_result,
  input  logic [3:0]        dp_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FP16_W-1:0] out_result,
  output logic [3:0]        out_flags,
  output logic              busy
`ifdef FMA16_PERF_EN
  ,
  output logic [15:0]       perf_ops,
  output logic [15:0]       perf_stall
`endif
);

  localparam logic [3:0] MUL_LD = 4'(MUL_CYC - 1);
  localparam logic [3:0] ALN_LD = 4'(ALN_CYC - 1);
  localparam logic [3:0] NRM_LD = 4'(NRM_CYC - 1);
  localparam logic [3:0] RND_LD = 4'(RND_CYC - 1);

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       accept, push, pop;
  logic       q_full, q_empty;
  logic [$clog2(OQ_DEPTH):0] q_count;
  logic [FP16_W+3:0]         q_head;
  flags_t                    head_flags;

  assign pop    = out_valid & out_ready;
  assign push   = (state == WB) & (~q_full | pop);
  assign accept = in_valid & in_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dp_en     = '0;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = MUL;
          cnt_nxt   = MUL_LD;
        end
      end
      MUL: begin
        dp_en[EN_MUL] = 1'b1;
        if (cnt == '0) begin
          state_nxt = ALN;
          cnt_nxt   = ALN_LD;
        end else cnt_nxt = cnt - 4'd1;
      end
      ALN: begin
        dp_en[EN_ALN] = 1'b1;
        if (cnt == '0) begin
          state_nxt = NRM;
          cnt_nxt   = NRM_LD;
        end else cnt_nxt = cnt - 4'd1;
      end
      NRM: begin
        dp_en[EN_NRM] = 1'b1;
        if (cnt == '0) begin
          state_nxt = RND;
          cnt_nxt   = RND_LD;
        end else cnt_nxt = cnt - 4'd1;
      end
      RND: begin
        dp_en[EN_RND] = 1'b1;
        if (cnt == '0) begin
          state_nxt = WB;
          cnt_nxt   = '0;
        end else cnt_nxt = cnt - 4'd1;
      end
      WB: begin
        if (push) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      dp_x    <= '0;
      dp_y    <= '0;
      dp_z    <= '0;
      dp_ctrl <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        dp_x    <= in_x;
        dp_y    <= in_y;
        dp_z    <= in_z;
        dp_ctrl <= in_ctrl;
      end
    end
  end

  fma16_outq #(
    .DEPTH (OQ_DEPTH),
    .W     (FP16_W + 4)
  ) u_outq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({dp_result, dp_flags}),
    .pop   (pop),
    .rdata (q_head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign head_flags = q_head[3:0];
  assign out_result = q_head[FP16_W+3:4];
  assign out_flags  = head_flags;
  assign out_valid  = ~q_empty;
  assign busy       = (state != IDLE) | (q_count != '0);

`ifdef FMA16_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (push && perf_ops != '1) perf_ops <= perf_ops + 16'd1;
      if (state == WB && !push && perf_stall != '1) perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule
